// File: rtl/dna_pkg.sv
// Shared types and constants for the nucleotide pattern matcher.
// Base encoding, reset-time pattern and one-hot press encoding.
package dna_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    localparam int DEF_LEN = 6;

    // The lab's original GGTCAG sequence, position 0 first
    localparam base_t DEF_PAT [DEF_LEN] = '{
        BASE_G, BASE_G, BASE_T, BASE_C, BASE_A, BASE_G
    };

    function automatic base_t default_base(input int idx);
        if (idx < DEF_LEN) begin
            return DEF_PAT[idx];
        end
        return BASE_A;
    endfunction

    // Press vector bit order is {T, G, C, A}, matching the code values
    function automatic base_t base_code(input logic [3:0] hot);
        if (hot[3]) return BASE_T;
        if (hot[2]) return BASE_G;
        if (hot[1]) return BASE_C;
        return BASE_A;
    endfunction

endpackage

// File: rtl/dna_if.sv
// Button, pattern-programming and indicator bundle of the matcher.
// The controller/board side is master, the matcher is slave.
interface dna_if #(
    parameter int PAT_LEN = 6,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    logic             A;
    logic             G;
    logic             C;
    logic             T;
    logic             clear;
    logic             pat_we;
    logic [IDX_W-1:0] pat_idx;
    logic [1:0]       pat_base;

    logic             base_valid;
    logic [1:0]       base_code;
    logic             mutant;
    logic             super_mutant;
    logic [CNT_W-1:0] mutant_cnt;
    logic [CNT_W-1:0] super_cnt;
    logic             err_multi;
    logic             locked;

    modport master (
        output A, G, C, T, clear, pat_we, pat_idx, pat_base,
        input  base_valid, base_code, mutant, super_mutant,
        input  mutant_cnt, super_cnt, err_multi, locked
    );

    modport slave (
        input  A, G, C, T, clear, pat_we, pat_idx, pat_base,
        output base_valid, base_code, mutant, super_mutant,
        output mutant_cnt, super_cnt, err_multi, locked
    );

endinterface

// File: rtl/dna_edge_encoder.sv
// Turns four debounced button levels into single-base press events.
// Flags cycles where more than one button rose at once.
module dna_edge_encoder
    import dna_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] level,
    output logic       new_base,
    output base_t      code,
    output logic       multi
);

    logic [3:0] prev;
    logic [3:0] rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise     = level & ~prev;
    assign new_base = $onehot(rise);
    assign multi    = (rise != 4'd0) && !$onehot(rise);
    assign code     = base_code(rise);

endmodule

// File: rtl/dna_pattern_matcher.sv
// Shift/compare matcher of a programmable base pattern and its prefix,
// with sticky flags, saturating counters and optional lock on full match.
module dna_pattern_matcher
    import dna_pkg::*;
#(
    parameter int PAT_LEN       = 6,
    parameter int PREFIX_LEN    = 4,
    parameter int CNT_W         = 8,
    parameter int LOCK_ON_SUPER = 1
) (
    input  logic clk,
    input  logic reset,
    dna_if.slave bus
);

    localparam int HW = 2 * PAT_LEN;
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL_F = FW'(PAT_LEN);
    localparam logic [FW-1:0] PRE_F  = FW'(PREFIX_LEN);

    base_t            pat [PAT_LEN];
    logic [HW-1:0]    hist;
    logic [HW-1:0]    hist_nx;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nx;
    logic             new_base;
    logic             multi;
    base_t            code;
    logic             idle;
    logic             accept;
    logic             reject;
    logic             pre_hit;
    logic             full_hit;
    logic             locked;

    logic             valid_q;
    base_t            code_q;
    logic             mutant_q;
    logic             super_q;
    logic [CNT_W-1:0] mcnt;
    logic [CNT_W-1:0] scnt;
    logic             err_q;

    dna_edge_encoder u_enc (
        .clk      (clk),
        .reset    (reset),
        .level    ({bus.T, bus.G, bus.C, bus.A}),
        .new_base (new_base),
        .code     (code),
        .multi    (multi)
    );

    // clear and pattern writes swallow any press on the same edge
    assign locked  = (LOCK_ON_SUPER != 0) && super_q;
    assign idle    = bus.clear || bus.pat_we || locked;
    assign accept  = new_base && !idle;
    assign reject  = multi && !idle;
    assign hist_nx = (hist << 2) | HW'(code);
    assign fill_nx = (fill == FULL_F) ? fill : fill + 1'b1;

    // Slot 0 holds the newest base, so it lines up with the last pattern entry
    always_comb begin
        pre_hit  = (fill_nx >= PRE_F);
        full_hit = (fill_nx == FULL_F);
        for (int j = 0; j < PREFIX_LEN; j++) begin
            if (hist_nx[2*j +: 2] != pat[PREFIX_LEN-1-j]) begin
                pre_hit = 1'b0;
            end
        end
        for (int j = 0; j < PAT_LEN; j++) begin
            if (hist_nx[2*j +: 2] != pat[PAT_LEN-1-j]) begin
                full_hit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAT_LEN; i++) begin
                pat[i] <= default_base(i);
            end
        end else if (!bus.clear && bus.pat_we &&
                     int'(bus.pat_idx) < PAT_LEN) begin
            pat[bus.pat_idx] <= base_t'(bus.pat_base);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.clear || bus.pat_we) begin
            hist <= '0;
            fill <= '0;
        end else if (accept) begin
            hist <= hist_nx;
            fill <= fill_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            code_q   <= BASE_A;
            mutant_q <= 1'b0;
            super_q  <= 1'b0;
            mcnt     <= '0;
            scnt     <= '0;
            err_q    <= 1'b0;
        end else if (bus.clear) begin
            valid_q  <= 1'b0;
            code_q   <= BASE_A;
            mutant_q <= 1'b0;
            super_q  <= 1'b0;
            mcnt     <= '0;
            scnt     <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= accept;
            err_q   <= reject;
            if (accept) begin
                code_q <= code;
                if (pre_hit) begin
                    mutant_q <= 1'b1;
                    if (mcnt != '1) mcnt <= mcnt + 1'b1;
                end
                if (full_hit) begin
                    super_q <= 1'b1;
                    if (scnt != '1) scnt <= scnt + 1'b1;
                end
            end
        end
    end

    assign bus.base_valid   = valid_q;
    assign bus.base_code    = code_q;
    assign bus.mutant       = mutant_q;
    assign bus.super_mutant = super_q;
    assign bus.mutant_cnt   = mcnt;
    assign bus.super_cnt    = scnt;
    assign bus.err_multi    = err_q;
    assign bus.locked       = locked;

endmodule

// File: doc/dna_pattern_matcher.md
# dna_pattern_matcher

Parametrised successor to the lab's fixed GGTC/GGTCAG detector. It accepts nucleotide button presses on four debounced level inputs (A, G, C, T) and converts each rising edge into one base. It matches the base stream against a runtime-programmable pattern of PAT_LEN bases, with overlap-correct detection of both a prefix ("mutant") and the full pattern ("super mutant"). It sits between the per-button debouncers and the board LEDs/7-segment counter display.

## Interface
- PAT_LEN, 6, full pattern length in bases (2..16)
- PREFIX_LEN, 4, prefix length that raises mutant (1..PAT_LEN)
- CNT_W, 8, width of the saturating match counters
- LOCK_ON_SUPER, 1, 1: ignore further bases once super_mutant is set, until clear or reset
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- A, G, C, T  in  1 each  debounced button levels
- clear  in  1  synchronous; clears flags, counters, history and lock; pattern kept
- pat_we  in  1  pattern write strobe
- pat_idx  in  $clog2(PAT_LEN)  pattern position, 0 = first base of sequence
- pat_base  in  2  base code written to pat_idx
- base_valid  out  1  one-cycle pulse: a base was accepted this edge
- base_code  out  2  code of last accepted base
- mutant  out  1  sticky: prefix seen
- super_mutant  out  1  sticky: full pattern seen
- mutant_cnt  out  CNT_W  prefix match count, saturating
- super_cnt  out  CNT_W  full match count, saturating
- err_multi  out  1  one-cycle pulse: more than one new press in the same cycle
- locked  out  1  LOCK_ON_SUPER && super_mutant

## Operation
- Base codes: A=0, C=1, G=2, T=3.
- Edge detect: per-channel prev-level register. A new press is level=1 and prev=0. A held button yields exactly one base.
- Exactly one new press in a cycle: base accepted. It is shifted into a 2·PAT_LEN-bit history (newest in the low slot), and fill count increments, saturating at PAT_LEN.
- Zero new presses: nothing happens.
- Two or more new presses: all are discarded, err_multi pulses, history unchanged. Prev registers still update.
- Prefix match: fill ≥ PREFIX_LEN and the newest PREFIX_LEN history bases equal pattern[0..PREFIX_LEN-1] in order. Evaluated on the post-shift history.
- Full match: fill ≥ PAT_LEN and the whole history equals pattern[0..PAT_LEN-1].
- Overlapping matches all count; no state reset after a match. This is a shift/compare, not a resetting FSM.
- Each match sets its sticky flag and increments its counter. Counters saturate at 2^CNT_W−1.
- While locked: presses are ignored. No base_valid, no history change, no err_multi.
- Pattern write: stores pat_base at pat_idx and flushes the history (fill=0). Flags and counters are unchanged.
- Precedence within one edge: clear > pat_we > base acceptance. A press coinciding with clear or pat_we is dropped, but its prev register still updates.

## Timing
- A press sampled high at posedge k (prev=0) updates the following at posedge k, visible from k: base_valid=1, history, flags, counters.
- base_valid and err_multi are high for exactly one cycle.
- Reset values:
  - All outputs 0.
  - History 0, fill 0, prev regs 0.
  - Pattern = G,G,T,C,A,G for PAT_LEN=6. For other PAT_LEN: pattern truncated, or padded with A.
- Button held through reset release: produces one press on the first posedge after release.
- Reset asserted mid-sequence: partial match lost, all outputs 0 immediately (asynchronous).
- clear: takes effect at the next posedge; the outputs are 0 from that edge.

## Structure
- Package dna_pkg: base_t (2-bit enum A/C/G/T), the default-pattern constant, and the base_code helper function.
- Sub-module dna_edge_encoder: four prev registers, one-hot→code encoding, multi-press detect. Outputs new_base, code, multi.
- The top holds the pattern RAM (registers), history, comparators, flags, counters and lock.
- Debouncers stay outside this block.

## Test plan
- Default pattern; press G,G,T,C,A,G with gaps of 3 cycles:
  - mutant rises at the C edge.
  - super_mutant rises at the last G edge.
  - mutant_cnt=1, super_cnt=1; locked=1.
  - A further G produces no base_valid.
- Program AAAAAA, PREFIX_LEN=4, LOCK_ON_SUPER=0; press A seven times:
  - mutant_cnt=4, super_cnt=2 (overlap).
- A and G rise in the same cycle:
  - err_multi pulses once, base_valid=0, history unchanged.
  - A subsequent G alone is accepted.
- T held for 20 cycles: exactly one base_valid, base_code=3.
- CNT_W=2, LOCK_ON_SUPER=0: six prefix matches give mutant_cnt=3 (saturated).
- Reset asserted asynchronously after G,G,T: all outputs 0 without a clock. Then G,G,T,C after release gives mutant=1 (no carry-over).
